// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter time-sharing one AXI-stream master among NUM_SRC slave streams.
// Grants are burst-limited, and every output beat is tagged with the index of its source.
module axis_rr_arbiter #(
    parameter int  NUM_SRC    = 4,
    parameter int  DATA_WIDTH = 512,
    parameter int  MAX_BURST  = 16,
    localparam int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC-1:0]            src_enable,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [SRC_W-1:0]              m_tsrc,
    output logic                          dbg_state
);

    // Handshake: a beat moves on any port only in a cycle where valid and ready are both
    // high at the rising edge; valid never waits on ready, and ready never looks at valid.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] last_idx;
    logic [7:0]       beat_cnt;

    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [NUM_SRC-1:0]    req;
    logic                  out_free;
    logic                  g_valid;
    logic                  g_en;
    logic                  xfer;
    logic                  last_beat;
    logic                  release_grant;
    logic                  found;
    logic [SRC_W-1:0]      pick;
    logic [SRC_W-1:0]      cand;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign req           = s_tvalid & src_enable;
    assign out_free      = !m_tvalid || m_tready;
    assign g_valid       = s_tvalid[grant_idx];
    assign g_en          = src_enable[grant_idx];
    assign xfer          = (state == GRANT) && g_valid && g_en && out_free;
    assign last_beat     = (beat_cnt == 8'(MAX_BURST - 1));
    assign release_grant = (state == GRANT) && ((xfer && last_beat) || !g_valid || !g_en);
    assign dbg_state     = (state == GRANT);

    always_comb begin
        s_tready = '0;
        if (state == GRANT && out_free && g_en) begin
            s_tready[grant_idx] = 1'b1;
        end
    end

    // Search starts one past the previous winner so the last holder has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((int'(last_idx) + k) % NUM_SRC);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= SRC_W'(NUM_SRC - 1);
            beat_cnt  <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tsrc    <= '0;
        end else begin
            if (xfer) begin
                m_tdata  <= src_data[grant_idx];
                m_tsrc   <= grant_idx;
                m_tvalid <= 1'b1;
            end else if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx <= pick;
                        beat_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    if (release_grant) begin
                        last_idx <= grant_idx;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: bench-side sources, round-robin chunking model, in-order scoreboard.
module tb_axis_rr_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int SW = $clog2(NS);
    localparam int W  = SW + DW;

    logic             clk;
    logic             ARESETN;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]    s_tvalid;
    logic [NS-1:0]    s_tready;
    logic [NS-1:0]    src_enable;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic [SW-1:0]    m_tsrc;
    logic             dbg_state;

    logic [DW-1:0] src_q [NS][$];
    logic [DW-1:0] ref_data [NS][$];
    logic [W-1:0]  exp_q[$];
    int            gap_at[$];
    int            acc_cnt [NS];
    logic [NS-1:0] en_mask;
    int            tests_run;
    int            tests_failed;
    int            cyc;
    int            out_cnt;
    int            gap_cnt;
    int            first_srdy;
    int            first_mval;
    int            first_src;
    int            model_last;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_src;

    axis_rr_arbiter #(
        .NUM_SRC   (NS),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .ACLK      (clk),
        .ARESETN   (ARESETN),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .src_enable(src_enable),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tsrc    (m_tsrc),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        ARESETN    = 1'b0;
        s_tvalid   = '0;
        s_tdata    = '0;
        m_tready   = 1'b0;
        en_mask    = '1;
        src_enable = '1;
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            ref_data[i].delete();
            acc_cnt[i] = 0;
        end
        exp_q.delete();
        gap_at.delete();
        cyc        = 0;
        out_cnt    = 0;
        gap_cnt    = 0;
        first_srdy = -1;
        first_mval = -1;
        first_src  = -1;
        prev_stall = 1'b0;
        model_last = NS - 1;
        repeat (2) @(negedge clk);
        ARESETN = 1'b1;
    endtask

    // ---------------- reference model ----------------
    task automatic gen_data(input int src, input int n);
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = $urandom;
            src_q[src].push_back(d);
            ref_data[src].push_back(d);
        end
    endtask

    task automatic push_exp(input int src, input int n);
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = ref_data[src].pop_front();
            exp_q.push_back({SW'(src), d});
        end
    endtask

    // Sources with data stay valid, so the output order is fixed: each turn goes to the
    // next source (after the previous winner) that still has data, for up to MB beats.
    task automatic model_rr();
        int pick;
        int n;
        while (1) begin
            pick = -1;
            for (int k = 1; k <= NS; k++) begin
                int c;
                c = (model_last + k) % NS;
                if (pick < 0 && ref_data[c].size() > 0) pick = c;
            end
            if (pick < 0) break;
            n = (ref_data[pick].size() < MB) ? ref_data[pick].size() : MB;
            push_exp(pick, n);
            model_last = pick;
        end
    endtask

    // ---------------- driver + scoreboard, one clock per call ----------------
    task automatic step(input int rdy_pct);
        logic [W-1:0] exp_beat;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i]         = 1'b1;
                s_tdata[i*DW +: DW] = src_q[i][0];
            end else begin
                s_tvalid[i]         = 1'b0;
                s_tdata[i*DW +: DW] = '0;
            end
        end
        src_enable = en_mask;
        m_tready   = (int'($urandom_range(0, 99)) < rdy_pct);
        #1;

        if (prev_stall) begin
            tests_run++;
            if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tsrc !== prev_src) begin
                tests_failed++;
                $display("FAIL hold_stable: got v=%b src=%0d data=%h, required v=1 src=%0d data=%h",
                         m_tvalid, m_tsrc, m_tdata, prev_src, prev_data);
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_src   = m_tsrc;

        tests_run++;
        if ($countones(s_tready) > 1 || (s_tready & ~src_enable) != '0 ||
            (m_tvalid && !m_tready && s_tready != '0)) begin
            tests_failed++;
            $display("FAIL ready_rules: s_tready=%b src_enable=%b m_tvalid=%b m_tready=%b",
                     s_tready, src_enable, m_tvalid, m_tready);
        end

        if (first_srdy < 0 && s_tready != '0) first_srdy = cyc;
        if (first_mval < 0 && m_tvalid) first_mval = cyc;

        for (int i = 0; i < NS; i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
                src_q[i].delete(0);
                acc_cnt[i]++;
            end
        end

        if (out_cnt > 0 && !m_tvalid && exp_q.size() > 0) begin
            gap_cnt++;
            gap_at.push_back(out_cnt);
        end

        if (m_tvalid && m_tready) begin
            if (first_src < 0) first_src = int'(m_tsrc);
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL extra_beat: got src=%0d data=%h, required no beat", m_tsrc, m_tdata);
            end else begin
                exp_beat = exp_q.pop_front();
                if ({m_tsrc, m_tdata} !== exp_beat) begin
                    tests_failed++;
                    $display("FAIL beat_%0d: got src=%0d data=%h, required src=%0d data=%h",
                             out_cnt, m_tsrc, m_tdata, exp_beat[W-1:DW], exp_beat[DW-1:0]);
                end
            end
            out_cnt++;
        end
    endtask

    task automatic drain(input int rdy_pct, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || m_tvalid) && n < budget) begin
            step(rdy_pct);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || m_tvalid) begin
            tests_failed++;
            $display("FAIL drain_timeout: got %0d beats still expected, required 0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        ARESETN    = 1'b0;
        s_tvalid   = '1;
        src_enable = '1;
        m_tready   = 1'b1;
        for (int i = 0; i < NS; i++) s_tdata[i*DW +: DW] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_m_tvalid: got %b, required 0", m_tvalid);
        end
        tests_run++;
        if (m_tdata !== '0) begin
            tests_failed++; $display("FAIL reset_m_tdata: got %h, required 0", m_tdata);
        end
        tests_run++;
        if (m_tsrc !== '0) begin
            tests_failed++; $display("FAIL reset_m_tsrc: got %0d, required 0", m_tsrc);
        end
        tests_run++;
        if (s_tready !== '0) begin
            tests_failed++; $display("FAIL reset_s_tready: got %b, required 0", s_tready);
        end
        tests_run++;
        if (dbg_state !== 1'b0) begin
            tests_failed++; $display("FAIL reset_state: got %b, required 0", dbg_state);
        end
        @(negedge clk);
        s_tvalid = '0;
        ARESETN  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0 || s_tready !== '0 || dbg_state !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_req: got v=%b rdy=%b st=%b, required 0/0/0", m_tvalid, s_tready, dbg_state);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        gen_data(2, 40);
        model_rr();
        drain(100, 500);
        tests_run++;
        if (first_srdy != 2 || first_mval != 3) begin
            tests_failed++;
            $display("FAIL grant_latency: got s_tready@%0d m_tvalid@%0d, required 2 and 3", first_srdy, first_mval);
        end
        tests_run++;
        if (gap_cnt != 2) begin
            tests_failed++; $display("FAIL single_bubbles: got %0d, required 2", gap_cnt);
        end
        tests_run++;
        if (gap_at.size() < 2 || gap_at[0] != 16 || gap_at[1] != 32) begin
            tests_failed++;
            $display("FAIL burst_split: got %0d bubbles, first after %0d beats, required after 16 and 32",
                     gap_at.size(), (gap_at.size() > 0) ? gap_at[0] : -1);
        end
        tests_run++;
        if (acc_cnt[2] != 40) begin
            tests_failed++; $display("FAIL single_accepted: got %0d, required 40", acc_cnt[2]);
        end
    endtask

    task automatic test_all_sources();
        do_reset();
        for (int i = 0; i < NS; i++) gen_data(i, 2 * MB);
        model_rr();
        drain(100, 1000);
        tests_run++;
        if (out_cnt != NS * 2 * MB || gap_cnt != 2 * NS - 1) begin
            tests_failed++;
            $display("FAIL all_sources: got %0d beats %0d bubbles, required %0d beats %0d bubbles",
                     out_cnt, gap_cnt, NS * 2 * MB, 2 * NS - 1);
        end
        tests_run++;
        if (first_src != 0) begin
            tests_failed++; $display("FAIL first_winner: got %0d, required 0", first_src);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        gen_data(1, 30);
        gen_data(3, 25);
        model_rr();
        drain(50, 2000);
        tests_run++;
        if (out_cnt != 55 || acc_cnt[1] != 30 || acc_cnt[3] != 25) begin
            tests_failed++;
            $display("FAIL bp_counts: got out=%0d acc1=%0d acc3=%0d, required 55/30/25", out_cnt, acc_cnt[1], acc_cnt[3]);
        end
    endtask

    task automatic test_early_release_wrap();
        do_reset();
        gen_data(2, 3);
        model_rr();
        drain(100, 200);
        gen_data(3, 5);
        gen_data(0, 4);
        model_rr();
        drain(100, 200);
        tests_run++;
        if (out_cnt != 12 || acc_cnt[3] != 5 || acc_cnt[0] != 4) begin
            tests_failed++;
            $display("FAIL early_release: got out=%0d acc3=%0d acc0=%0d, required 12/5/4", out_cnt, acc_cnt[3], acc_cnt[0]);
        end
    endtask

    task automatic test_mask();
        int n;
        do_reset();
        gen_data(1, 20);
        gen_data(2, 20);
        push_exp(1, 7);
        push_exp(2, MB);
        push_exp(2, 4);
        n = 0;
        while (acc_cnt[1] < 7 && n < 200) begin
            step(100);
            n++;
        end
        en_mask[1] = 1'b0;
        n = 0;
        while ((exp_q.size() > 0 || m_tvalid) && n < 400) begin
            step(70);
            n++;
        end
        repeat (4) step(70);
        tests_run++;
        if (acc_cnt[1] != 7 || src_q[1].size() != 13) begin
            tests_failed++;
            $display("FAIL mask_block: got acc1=%0d left=%0d, required 7/13", acc_cnt[1], src_q[1].size());
        end
        tests_run++;
        if (acc_cnt[2] != 20 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL mask_handover: got acc2=%0d pending=%0d, required 20/0", acc_cnt[2], exp_q.size());
        end
        en_mask[1] = 1'b1;
        push_exp(1, 13);
        drain(70, 400);
        tests_run++;
        if (acc_cnt[1] != 20) begin
            tests_failed++; $display("FAIL mask_resume: got acc1=%0d, required 20", acc_cnt[1]);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        gen_data(1, 10);
        model_rr();
        repeat (4) step(100);
        repeat (2) step(0);
        tests_run++;
        if (m_tvalid !== 1'b1) begin
            tests_failed++; $display("FAIL stall_hold: got m_tvalid=%b, required 1", m_tvalid);
        end
        #2;
        ARESETN = 1'b0;
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0 || s_tready !== '0 || dbg_state !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%b rdy=%b st=%b, required 0/0/0", m_tvalid, s_tready, dbg_state);
        end
        do_reset();
        for (int i = 0; i < NS; i++) gen_data(i, 3);
        model_rr();
        drain(100, 300);
        tests_run++;
        if (first_src != 0) begin
            tests_failed++; $display("FAIL post_reset_winner: got %0d, required 0", first_src);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ARESETN      = 1'b0;
        s_tvalid     = '0;
        s_tdata      = '0;
        src_enable   = '0;
        m_tready     = 1'b0;
        en_mask      = '1;
        test_reset();
        test_single_source();
        test_all_sources();
        test_backpressure();
        test_early_release_wrap();
        test_mask();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin arbiter that shares one `stream` master among `NUM_SRC` `stream` slaves with burst-limited grants. Each grant carries the winning source's beats onto a registered output stage and tags every output beat with a source-index sideband. It sits in front of any single-consumer datapath (DMA engine, CMAC TX, QDMA H2C) that has to be time-shared between user-logic requesters.

## Interface
- `NUM_SRC`, 4: number of slave streams (2..16).
- `DATA_WIDTH`, 512: tdata width per stream.
- `MAX_BURST`, 16: maximum beats per grant (1..256).
- `SRC_W`, $clog2(NUM_SRC): width of the source-index sideband (derived, not overridden).
- `ACLK` in 1: single clock; every output is registered on its rising edge except `s_tready`.
- `ARESETN` in 1: asynchronous, active-low reset.
- `s_tdata` in NUM_SRC*DATA_WIDTH: slave data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_tvalid` in NUM_SRC: slave valid, one bit per source.
- `s_tready` out NUM_SRC: slave ready, one bit per source; combinational.
- `src_enable` in NUM_SRC: per-source arbitration mask (1 = eligible).
- `m_tdata` out DATA_WIDTH: master data, registered.
- `m_tvalid` out 1: master valid, registered.
- `m_tready` in 1: master ready.
- `m_tsrc` out SRC_W: index of the source that produced the current `m_tdata`, registered.

## Operation
- State machine with two states, IDLE and GRANT, plus these registers: `grant_idx` (SRC_W bits), `last_idx` (SRC_W bits), `beat_cnt` (8 bits).
- **IDLE:**
  - Form `req = s_tvalid & src_enable`.
  - If `req` is nonzero, select the first set bit at or after `last_idx+1`, wrapping modulo NUM_SRC.
  - Load that index into `grant_idx`, clear `beat_cnt`, and go to GRANT.
  - If `req` is zero, stay in IDLE.
- **GRANT:**
  - Define `out_free = !m_tvalid || m_tready`.
  - `s_tready[grant_idx] = out_free && src_enable[grant_idx]`. Every other `s_tready` bit is 0.
  - A transfer occurs when `s_tvalid[grant_idx] && s_tready[grant_idx]`. On a transfer: `m_tdata <= s_tdata[grant_idx]`, `m_tsrc <= grant_idx`, `m_tvalid <= 1`, `beat_cnt <= beat_cnt+1`.
- **Release from GRANT to IDLE, with `last_idx <= grant_idx`,** when any of these holds:
  - (a) a transfer occurs with `beat_cnt == MAX_BURST-1`;
  - (b) `s_tvalid[grant_idx] == 0`;
  - (c) `src_enable[grant_idx] == 0`.
- For (b) and (c), no transfer occurs in the release cycle.
- **Output stage:** when `m_tvalid && m_tready` and no new transfer occurs in the same cycle, `m_tvalid <= 0`. `m_tdata` and `m_tsrc` hold their value while `m_tvalid && !m_tready`. There is no beat loss and no duplication.
- In IDLE all `s_tready` bits are 0, and the output stage still drains.
- **Fairness:** after a grant ends, the source that held it has the lowest priority in the next arbitration. No eligible source waits more than (NUM_SRC-1) grants.
- Beat order within one source is preserved. Beats from different grants never interleave on `m_tdata`.

## Timing
- **Reset values** (asynchronous assertion; synchronous release at the first `ACLK` edge with `ARESETN` high):
  - state = IDLE, `grant_idx` = 0, `last_idx` = NUM_SRC-1 (so source 0 wins first), `beat_cnt` = 0.
  - `m_tvalid` = 0, `m_tdata` = 0, `m_tsrc` = 0, `s_tready` = 0.
- **Reset mid-burst:** any held beat is discarded and the block returns to IDLE. Sources must reassert after reset.
- **Grant latency:** a request first seen in IDLE at edge k enters GRANT at edge k+1. `s_tready` is high during cycle k+1, and the first beat appears on `m_tvalid` after edge k+2.
- **Throughput:** one beat per cycle within a grant while `m_tready` stays high. Each grant change costs one IDLE bubble cycle, so the steady-state maximum is MAX_BURST/(MAX_BURST+1).
- **Combinational path:** `m_tready` to `s_tready` (one AND level plus the one-hot index decode). No path from `s_tvalid` to `s_tready`.
- **Backpressure:** with `m_tready` held low, at most one beat is held in the output stage. `s_tready` stays 0 until that beat drains.
- **Mask change:** `src_enable` may change on any cycle. The change is applied in the same cycle in GRANT, and at the next arbitration in IDLE.
- **Wrap-around:** when `last_idx` = NUM_SRC-1, the search starts at index 0.

## Test plan
- **Single source:** after reset, source 2 streams 40 beats with `m_tready`=1 and MAX_BURST=16 → three grants (16, 16, 8 beats) with one bubble cycle between them; `m_tsrc`=2 on every beat; data in order.
- **All four sources continuously valid:** grants follow 0,1,2,3,0…, each exactly 16 beats; `m_tsrc` sequence matches; no beats from different sources are interleaved.
- **Backpressure:** toggle `m_tready` pseudo-randomly at 50% with two sources active → scoreboard shows every beat delivered exactly once, in order per source; `m_tdata` is stable while `m_tvalid && !m_tready`.
- **Early release and wrap:** source 3 sends 5 beats then drops `s_tvalid`; source 0 is pending → grant releases after beat 5, and source 0 is granted next (wrap from 3 to 0).
- **Mask:** clear `src_enable[1]` during beat 7 of source 1's grant → source 1 gets no further `s_tready`, and the grant passes to source 2; source 1 is never granted while masked.
- **Reset mid-burst:** assert `ARESETN`=0 asynchronously between edges during a stalled beat → `m_tvalid` and all `s_tready` drop immediately; after release, source 0 is granted first.
